// File: rtl/tdm_demux_16.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_16
// Description : Sixteen-channel time-division demultiplexer. Collects a
//               bit-serial stream (channel 0 marked by in_sof) into a 16-bit
//               parallel frame and presents it with a one-cycle valid strobe.
//               Framing violations raise a one-cycle frame_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_16 #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_bit,
  input  logic                in_sof,
  output logic [CHANNELS-1:0] out_data,
  output logic                out_valid,
  output logic [SEL_W-1:0]    sel_out,
  output logic                frame_err,
  output logic                busy
);

  // Last channel index: the beat that completes a frame.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                state_q,     state_d;
  logic [SEL_W-1:0]      ch_q,        ch_d;
  logic [CHANNELS-2:0]   shadow_q,    shadow_d;
  logic [CHANNELS-1:0]   out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_err_q, frame_err_d;

  // Next-state and output computation; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          // Hunting for sync: only an SOF beat is taken, others are dropped silently.
          if (in_sof) begin
            shadow_d[0] = in_bit;
            ch_d        = SEL_W'(1);
            state_d     = COLLECT;
          end
        end

        COLLECT: begin
          if (in_sof) begin
            // SOF at channel 0 is a normal frame start; anywhere else it is a
            // resync that abandons the partial frame.
            if (ch_q != '0) begin
              frame_err_d = 1'b1;
            end
            shadow_d[0] = in_bit;
            ch_d        = SEL_W'(1);
          end else if (ch_q == '0) begin
            // Expected a new frame start but sync was lost.
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (ch_q == LAST_CH) begin
            out_data_d  = {in_bit, shadow_q};
            out_valid_d = 1'b1;
            ch_d        = '0;
          end else begin
            for (int i = 1; i < CHANNELS - 1; i++) begin
              if (ch_q == SEL_W'(i)) begin
                shadow_d[i] = in_bit;
              end
            end
            ch_d = ch_q + SEL_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign sel_out   = ch_q;
  assign busy      = (state_q == COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux_16
// Description : Scoreboard bench for tdm_demux_16. A frame-level reference
//               model predicts frame / error events into a queue; a monitor
//               pops and compares them as the DUT presents pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        in_sof;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  sel_out;
  logic        frame_err;
  logic        busy;

  tdm_demux_16 #(.CHANNELS(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sel_out   (sel_out),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Expected output events, tagged with the cycle they must appear in.
  typedef struct {
    bit          is_err;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: bits collected so far in the current frame, and whether
  // the receiver is locked to a frame.
  bit m_bits[$];
  bit m_locked;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_event(input bit is_err, input logic [15:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.cyc    = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Frame-level behaviour: a frame is 16 beats opening with SOF.
  task automatic model_step(input bit v, input bit sof, input bit b);
    logic [15:0] word;
    if (!v) return;
    if (sof) begin
      if (m_locked && m_bits.size() != 0) push_event(1'b1, 16'h0);
      m_bits.delete();
      m_bits.push_back(b);
      m_locked = 1'b1;
    end else if (m_locked) begin
      if (m_bits.size() == 0) begin
        push_event(1'b1, 16'h0);
        m_locked = 1'b0;
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == 16) begin
          word = '0;
          foreach (m_bits[k]) word = word + (16'(m_bits[k]) << k);
          push_event(1'b0, word);
          m_bits.delete();
        end
      end
    end
  endtask

  // Monitor: compare every DUT pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && frame_err) begin
        compared++;
        mismatched++;
        $display("FAIL overlap: out_valid and frame_err both high at t=%0t", $time);
      end
      if (out_valid || frame_err) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse: got valid=%b err=%b expected none at t=%0t",
                   out_valid, frame_err, $time);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err != frame_err || e.cyc != cyc ||
              (!e.is_err && out_data !== e.data)) begin
            mismatched++;
            $display("FAIL event: got err=%b data=%h cyc=%0d expected err=%b data=%h cyc=%0d",
                     frame_err, out_data, cyc, e.is_err, e.data, e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        compared++;
        mismatched++;
        e = exp_q.pop_front();
        $display("FAIL missing_pulse: got none expected err=%b data=%h cyc=%0d",
                 e.is_err, e.data, e.cyc);
      end
    end
  end

  // One beat (or idle cycle): drive at negedge, then check counter/busy.
  task automatic beat(input bit v, input bit sof, input bit b);
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_bit   = b;
    model_step(v, sof, b);
    @(posedge clk);
    #1;
    chk("sel_out", 32'(sel_out), 32'(m_bits.size()));
    chk("busy", 32'(busy), 32'(m_locked));
  endtask

  task automatic send_frame(input logic [15:0] d);
    for (int i = 0; i < 16; i++) beat(1'b1, i == 0, d[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] pat;
    bit v, s;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_sof   = 1'b0;
    m_locked = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_sel_out", 32'(sel_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame
    send_frame(16'hA5C3);
    idle(2);

    // Back-to-back frames
    send_frame(16'h0001);
    send_frame(16'h8000);
    idle(2);

    // Stalls mid-frame
    pat = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, i == 0, pat[i]);
      if (i == 5)  idle(3);
      if (i == 12) idle(1);
    end
    idle(2);

    // Early SOF at beat 9, then a clean all-ones frame
    pat = 16'h0F0F;
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0, pat[i]);
    send_frame(16'hFFFF);

    // Missing SOF right after a good frame, then ignored beats, then recovery
    beat(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'(i));
    send_frame(16'hC0DE);
    idle(2);

    // Asynchronous reset during beat 7
    pat = 16'h5A5A;
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0, pat[i]);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_bit   = pat[7];
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_data", 32'(out_data), 32'h0);
    chk("async_sel_out", 32'(sel_out), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_pending", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    m_bits.delete();
    m_locked = 1'b0;
    #4 rst_n = 1'b1;
    in_valid = 1'b0;
    send_frame(16'h5A5A);
    idle(2);

    // Randomized traffic with stalls, early SOFs and missing SOFs
    for (int n = 0; n < 2000; n++) begin
      v = ($urandom_range(0, 9) != 0);
      if (m_bits.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                    s = ($urandom_range(0, 39) == 0);
      beat(v, s, 1'($urandom));
    end
    idle(3);
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
